// File: rtl/mcu_bus_pkg.sv
// Shared types and constants for the CPU-side memory bus controller.
// Decodes the top address nibble into the peripheral or external memory region.
package mcu_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    P_ACCESS,
    P_WAIT,
    M_ACCESS,
    DONE
  } bus_state_t;

  typedef enum logic {
    REGION_PERIPH,
    REGION_MEM
  } region_t;

  localparam logic [3:0] PERIPH_REGION    = 4'hF;
  localparam logic [7:0] ERR_DATA_DEFAULT = 8'hFF;

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
    logic       write_en;
    logic       valid;
  } periph_port_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        write_en;
    logic        req;
  } mem_port_t;

  function automatic region_t decode_region(input logic [15:0] addr);
    return (addr[15:12] == PERIPH_REGION) ? REGION_PERIPH : REGION_MEM;
  endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// Saturating cycle counter that flags expiry after LIMIT enabled cycles.
// LIMIT of 0 disables expiry entirely.
module bus_timeout_counter #(
  parameter int WIDTH = 8,
  parameter int LIMIT = 255
) (
  input  logic clk_in,
  input  logic reset_in,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int              LAST_INT = (LIMIT > 0) ? LIMIT - 1 : 0;
  localparam logic [WIDTH-1:0] LAST    = LAST_INT[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SAT     = '1;

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != SAT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The count reflects cycles already spent, so the LIMIT-th cycle sees LIMIT-1.
  assign expired = (LIMIT != 0) && enable && !clear && (cnt_q >= LAST);

endmodule

// File: rtl/mcu_bus_ctrl.sv
// CPU load/store front end: routes 0xF000-0xFFFF to the 4-bit peripheral bus and
// everything else to a valid/ready memory port, with timeout completions on both.
module mcu_bus_ctrl
  import mcu_bus_pkg::*;
#(
  parameter int         PERIPH_TIMEOUT = 4,
  parameter int         MEM_TIMEOUT    = 255,
  parameter logic [7:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic [15:0] cpu_addr_in,
  input  logic [7:0]  cpu_data_in,
  input  logic        cpu_write_en_in,
  input  logic        cpu_req_in,
  output logic [7:0]  cpu_data_out,
  output logic        cpu_ack_out,
  output logic        cpu_err_out,
  output logic [3:0]  periph_addr_out,
  output logic        periph_addr_valid_out,
  output logic        periph_write_en_out,
  output logic [7:0]  periph_data_out,
  input  logic [7:0]  periph_data_in,
  input  logic        periph_data_valid_in,
  output logic [15:0] mem_addr_out,
  output logic [7:0]  mem_data_out,
  output logic        mem_write_en_out,
  output logic        mem_req_out,
  input  logic [7:0]  mem_data_in,
  input  logic        mem_ready_in
);

  bus_state_t   state_q, state_d;
  periph_port_t periph_q, periph_d;
  mem_port_t    mem_q, mem_d;
  logic [7:0]   cpu_data_q, cpu_data_d;
  logic         ack_q, ack_d;
  logic         err_q, err_d;

  logic periph_expired;
  logic mem_expired;

  bus_timeout_counter #(
    .WIDTH (4),
    .LIMIT (PERIPH_TIMEOUT)
  ) u_periph_timer (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .clear    (state_q != P_WAIT),
    .enable   (state_q == P_WAIT),
    .expired  (periph_expired)
  );

  bus_timeout_counter #(
    .WIDTH (8),
    .LIMIT (MEM_TIMEOUT)
  ) u_mem_timer (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .clear    (state_q != M_ACCESS),
    .enable   ((state_q == M_ACCESS) && !mem_ready_in),
    .expired  (mem_expired)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d        = state_q;
    periph_d       = periph_q;
    periph_d.valid = 1'b0;
    mem_d          = mem_q;
    cpu_data_d     = cpu_data_q;
    ack_d          = 1'b0;
    err_d          = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cpu_req_in) begin
          if (decode_region(cpu_addr_in) == REGION_PERIPH) begin
            periph_d.addr     = cpu_addr_in[3:0];
            periph_d.data     = cpu_data_in;
            periph_d.write_en = cpu_write_en_in;
            periph_d.valid    = 1'b1;
            state_d           = P_ACCESS;
          end else begin
            mem_d.addr     = cpu_addr_in;
            mem_d.data     = cpu_data_in;
            mem_d.write_en = cpu_write_en_in;
            mem_d.req      = 1'b1;
            state_d        = M_ACCESS;
          end
        end
      end

      P_ACCESS: begin
        if (periph_q.write_en) begin
          ack_d   = 1'b1;
          state_d = DONE;
        end else begin
          state_d = P_WAIT;
        end
      end

      P_WAIT: begin
        if (periph_data_valid_in) begin
          cpu_data_d = periph_data_in;
          ack_d      = 1'b1;
          state_d    = DONE;
        end else if (periph_expired) begin
          cpu_data_d = ERR_DATA;
          ack_d      = 1'b1;
          err_d      = 1'b1;
          state_d    = DONE;
        end
      end

      M_ACCESS: begin
        if (mem_ready_in) begin
          if (!mem_q.write_en) begin
            cpu_data_d = mem_data_in;
          end
          mem_d.req = 1'b0;
          ack_d     = 1'b1;
          state_d   = DONE;
        end else if (mem_expired) begin
          if (!mem_q.write_en) begin
            cpu_data_d = ERR_DATA;
          end
          mem_d.req = 1'b0;
          ack_d     = 1'b1;
          err_d     = 1'b1;
          state_d   = DONE;
        end
      end

      // Ack is already on the outputs here; any pending request waits for IDLE.
      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q    <= IDLE;
      periph_q   <= '0;
      mem_q      <= '0;
      cpu_data_q <= 8'h00;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      periph_q   <= periph_d;
      mem_q      <= mem_d;
      cpu_data_q <= cpu_data_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

  assign cpu_data_out          = cpu_data_q;
  assign cpu_ack_out           = ack_q;
  assign cpu_err_out           = err_q;
  assign periph_addr_out       = periph_q.addr;
  assign periph_addr_valid_out = periph_q.valid;
  assign periph_write_en_out   = periph_q.write_en;
  assign periph_data_out       = periph_q.data;
  assign mem_addr_out          = mem_q.addr;
  assign mem_data_out          = mem_q.data;
  assign mem_write_en_out      = mem_q.write_en;
  assign mem_req_out           = mem_q.req;

endmodule

// File: tb/tb_mcu_bus_ctrl.sv
// Directed bench for mcu_bus_ctrl: a default instance plus a shadow instance with
// the memory timeout disabled, both fed the same CPU and bus stimulus.
module tb_mcu_bus_ctrl;
  import mcu_bus_pkg::*;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic [15:0] cpu_addr_in;
  logic [7:0]  cpu_data_in;
  logic        cpu_write_en_in;
  logic        cpu_req_in;
  logic [7:0]  periph_data_in;
  logic        periph_data_valid_in;
  logic [7:0]  mem_data_in;
  logic        mem_ready_in;

  logic [7:0]  cpu_data_out;
  logic        cpu_ack_out, cpu_err_out;
  logic [3:0]  periph_addr_out;
  logic        periph_addr_valid_out, periph_write_en_out;
  logic [7:0]  periph_data_out;
  logic [15:0] mem_addr_out;
  logic [7:0]  mem_data_out;
  logic        mem_write_en_out, mem_req_out;

  logic [7:0]  nt_cpu_data_out;
  logic        nt_cpu_ack_out, nt_cpu_err_out;
  logic [3:0]  nt_periph_addr_out;
  logic        nt_periph_addr_valid_out, nt_periph_write_en_out;
  logic [7:0]  nt_periph_data_out;
  logic [15:0] nt_mem_addr_out;
  logic [7:0]  nt_mem_data_out;
  logic        nt_mem_write_en_out, nt_mem_req_out;

  int n_checks = 0;
  int n_fail   = 0;
  int ack_cnt  = 0;
  int err_cnt  = 0;
  int req_cyc  = 0;
  int nt_ack_cnt = 0;
  int a0, e0, m0, n0;

  always #5 clk_in = ~clk_in;

  mcu_bus_ctrl dut (
    .clk_in                (clk_in),
    .reset_in              (reset_in),
    .cpu_addr_in           (cpu_addr_in),
    .cpu_data_in           (cpu_data_in),
    .cpu_write_en_in       (cpu_write_en_in),
    .cpu_req_in            (cpu_req_in),
    .cpu_data_out          (cpu_data_out),
    .cpu_ack_out           (cpu_ack_out),
    .cpu_err_out           (cpu_err_out),
    .periph_addr_out       (periph_addr_out),
    .periph_addr_valid_out (periph_addr_valid_out),
    .periph_write_en_out   (periph_write_en_out),
    .periph_data_out       (periph_data_out),
    .periph_data_in        (periph_data_in),
    .periph_data_valid_in  (periph_data_valid_in),
    .mem_addr_out          (mem_addr_out),
    .mem_data_out          (mem_data_out),
    .mem_write_en_out      (mem_write_en_out),
    .mem_req_out           (mem_req_out),
    .mem_data_in           (mem_data_in),
    .mem_ready_in          (mem_ready_in)
  );

  mcu_bus_ctrl #(.MEM_TIMEOUT(0)) dut_nt (
    .clk_in                (clk_in),
    .reset_in              (reset_in),
    .cpu_addr_in           (cpu_addr_in),
    .cpu_data_in           (cpu_data_in),
    .cpu_write_en_in       (cpu_write_en_in),
    .cpu_req_in            (cpu_req_in),
    .cpu_data_out          (nt_cpu_data_out),
    .cpu_ack_out           (nt_cpu_ack_out),
    .cpu_err_out           (nt_cpu_err_out),
    .periph_addr_out       (nt_periph_addr_out),
    .periph_addr_valid_out (nt_periph_addr_valid_out),
    .periph_write_en_out   (nt_periph_write_en_out),
    .periph_data_out       (nt_periph_data_out),
    .periph_data_in        (periph_data_in),
    .periph_data_valid_in  (periph_data_valid_in),
    .mem_addr_out          (nt_mem_addr_out),
    .mem_data_out          (nt_mem_data_out),
    .mem_write_en_out      (nt_mem_write_en_out),
    .mem_req_out           (nt_mem_req_out),
    .mem_data_in           (mem_data_in),
    .mem_ready_in          (mem_ready_in)
  );

  // Event counters sampled on the falling edge, away from the active edge.
  always @(negedge clk_in) begin
    if (cpu_ack_out)    ack_cnt    <= ack_cnt + 1;
    if (cpu_err_out)    err_cnt    <= err_cnt + 1;
    if (mem_req_out)    req_cyc    <= req_cyc + 1;
    if (nt_cpu_ack_out) nt_ack_cnt <= nt_ack_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected finish before 200000ns");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_req(input logic [15:0] addr, input logic [7:0] data, input logic we);
    cpu_addr_in     = addr;
    cpu_data_in     = data;
    cpu_write_en_in = we;
    cpu_req_in      = 1'b1;
  endtask

  task automatic cpu_idle();
    cpu_req_in      = 1'b0;
    cpu_addr_in     = 16'h0000;
    cpu_data_in     = 8'h00;
    cpu_write_en_in = 1'b0;
  endtask

  initial begin
    reset_in             = 1'b1;
    cpu_idle();
    periph_data_in       = 8'h00;
    periph_data_valid_in = 1'b0;
    mem_data_in          = 8'h00;
    mem_ready_in         = 1'b0;
    tick();
    tick();

    // Reset values
    check("rst_ack",      cpu_ack_out, 0);
    check("rst_err",      cpu_err_out, 0);
    check("rst_cpu_data", cpu_data_out, 0);
    check("rst_pvalid",   periph_addr_valid_out, 0);
    check("rst_paddr",    periph_addr_out, 0);
    check("rst_pdata",    periph_data_out, 0);
    check("rst_pwe",      periph_write_en_out, 0);
    check("rst_mreq",     mem_req_out, 0);
    check("rst_maddr",    mem_addr_out, 0);
    check("rst_mdata",    mem_data_out, 0);
    check("rst_mwe",      mem_write_en_out, 0);
    check("rst_state",    dut.state_q, IDLE);
    reset_in = 1'b0;
    tick();

    // 1: peripheral store
    m0 = req_cyc; a0 = ack_cnt;
    cpu_req(16'hF001, 8'h5A, 1'b1);
    tick();
    cpu_idle();
    check("t1_strobe",    periph_addr_valid_out, 1);
    check("t1_paddr",     periph_addr_out, 4'h1);
    check("t1_pwe",       periph_write_en_out, 1);
    check("t1_pdata",     periph_data_out, 8'h5A);
    check("t1_ack_early", cpu_ack_out, 0);
    tick();
    check("t1_ack",       cpu_ack_out, 1);
    check("t1_err",       cpu_err_out, 0);
    check("t1_strobe_off", periph_addr_valid_out, 0);
    tick();
    check("t1_ack_off",   cpu_ack_out, 0);
    check("t1_idle",      dut.state_q, IDLE);
    tick();
    check("t1_no_mreq",   req_cyc - m0, 0);
    check("t1_one_ack",   ack_cnt - a0, 1);

    // 2: peripheral load with one-cycle response, then a store keeps read data
    cpu_req(16'hF002, 8'h00, 1'b0);
    tick();
    cpu_idle();
    check("t2_strobe",    periph_addr_valid_out, 1);
    check("t2_paddr",     periph_addr_out, 4'h2);
    check("t2_pwe",       periph_write_en_out, 0);
    tick();
    periph_data_valid_in = 1'b1;
    periph_data_in       = 8'h3C;
    check("t2_ack_early", cpu_ack_out, 0);
    tick();
    periph_data_valid_in = 1'b0;
    periph_data_in       = 8'h00;
    check("t2_ack",       cpu_ack_out, 1);
    check("t2_data",      cpu_data_out, 8'h3C);
    check("t2_err",       cpu_err_out, 0);
    tick();
    cpu_req(16'hF003, 8'h11, 1'b1);
    tick();
    cpu_idle();
    tick();
    check("t2_st_ack",    cpu_ack_out, 1);
    check("t2_hold",      cpu_data_out, 8'h3C);
    tick();

    // 3: stray valid outside P_WAIT is ignored, then peripheral timeout
    periph_data_valid_in = 1'b1;
    periph_data_in       = 8'h77;
    tick();
    check("t3_stray_ack",  cpu_ack_out, 0);
    check("t3_stray_data", cpu_data_out, 8'h3C);
    cpu_req(16'hF006, 8'h00, 1'b0);
    tick();
    cpu_idle();
    check("t3_strobe",    periph_addr_valid_out, 1);
    check("t3_paddr",     periph_addr_out, 4'h6);
    tick();
    periph_data_valid_in = 1'b0;
    periph_data_in       = 8'h00;
    for (int i = 0; i < 4; i++) begin
      check("t3_wait_ack", cpu_ack_out, 0);
      tick();
    end
    check("t3_ack",       cpu_ack_out, 1);
    check("t3_err",       cpu_err_out, 1);
    check("t3_data",      cpu_data_out, 8'hFF);
    tick();
    check("t3_err_off",   cpu_err_out, 0);

    // 4: memory load, ready on the third request cycle
    m0 = req_cyc; a0 = ack_cnt;
    cpu_req(16'h1234, 8'h00, 1'b0);
    tick();
    cpu_idle();
    check("t4_mreq1",     mem_req_out, 1);
    check("t4_maddr1",    mem_addr_out, 16'h1234);
    check("t4_mwe",       mem_write_en_out, 0);
    check("t4_no_strobe", periph_addr_valid_out, 0);
    tick();
    check("t4_mreq2",     mem_req_out, 1);
    check("t4_maddr2",    mem_addr_out, 16'h1234);
    check("t4_ack_early", cpu_ack_out, 0);
    tick();
    check("t4_mreq3",     mem_req_out, 1);
    check("t4_maddr3",    mem_addr_out, 16'h1234);
    mem_ready_in = 1'b1;
    mem_data_in  = 8'hA5;
    tick();
    mem_ready_in = 1'b0;
    mem_data_in  = 8'h00;
    check("t4_ack",       cpu_ack_out, 1);
    check("t4_data",      cpu_data_out, 8'hA5);
    check("t4_mreq_off",  mem_req_out, 0);
    check("t4_err",       cpu_err_out, 0);
    tick();
    tick();
    check("t4_req_cycles", req_cyc - m0, 3);
    check("t4_one_ack",    ack_cnt - a0, 1);

    // 5: reset mid memory store, then decode boundaries
    cpu_req(16'h0100, 8'h42, 1'b1);
    tick();
    cpu_idle();
    check("t5_mreq",      mem_req_out, 1);
    check("t5_mdata",     mem_data_out, 8'h42);
    check("t5_mwe",       mem_write_en_out, 1);
    tick();
    reset_in = 1'b1;
    a0 = ack_cnt; e0 = err_cnt;
    tick();
    reset_in = 1'b0;
    check("t5_rst_mreq",  mem_req_out, 0);
    check("t5_rst_maddr", mem_addr_out, 0);
    check("t5_rst_mdata", mem_data_out, 0);
    check("t5_rst_mwe",   mem_write_en_out, 0);
    check("t5_rst_data",  cpu_data_out, 0);
    check("t5_rst_state", dut.state_q, IDLE);
    tick();
    tick();
    check("t5_no_ack",    ack_cnt - a0, 0);
    check("t5_no_err",    err_cnt - e0, 0);

    cpu_req(16'hEFFF, 8'h00, 1'b0);
    mem_ready_in = 1'b1;
    mem_data_in  = 8'h96;
    tick();
    cpu_idle();
    check("t5_efff_mreq",   mem_req_out, 1);
    check("t5_efff_strobe", periph_addr_valid_out, 0);
    check("t5_efff_addr",   mem_addr_out, 16'hEFFF);
    tick();
    mem_ready_in = 1'b0;
    mem_data_in  = 8'h00;
    check("t5_efff_ack",    cpu_ack_out, 1);
    check("t5_efff_data",   cpu_data_out, 8'h96);
    check("t5_efff_off",    mem_req_out, 0);
    tick();

    cpu_req(16'hF000, 8'h00, 1'b0);
    tick();
    cpu_idle();
    check("t5_f000_strobe", periph_addr_valid_out, 1);
    check("t5_f000_paddr",  periph_addr_out, 4'h0);
    check("t5_f000_mreq",   mem_req_out, 0);
    tick();
    periph_data_valid_in = 1'b1;
    periph_data_in       = 8'hC3;
    tick();
    periph_data_valid_in = 1'b0;
    periph_data_in       = 8'h00;
    check("t5_f000_ack",    cpu_ack_out, 1);
    check("t5_f000_data",   cpu_data_out, 8'hC3);
    tick();

    cpu_req(16'hFFFF, 8'h81, 1'b1);
    tick();
    cpu_idle();
    check("t5_ffff_strobe", periph_addr_valid_out, 1);
    check("t5_ffff_paddr",  periph_addr_out, 4'hF);
    check("t5_ffff_pdata",  periph_data_out, 8'h81);
    check("t5_ffff_mreq",   mem_req_out, 0);
    tick();
    check("t5_ffff_ack",    cpu_ack_out, 1);
    tick();

    // 6: request held across the ack starts exactly one transaction after IDLE
    a0 = ack_cnt;
    cpu_req(16'h2000, 8'h00, 1'b0);
    mem_ready_in = 1'b1;
    mem_data_in  = 8'h11;
    tick();
    check("t6_mreq_a",    mem_req_out, 1);
    check("t6_maddr_a",   mem_addr_out, 16'h2000);
    cpu_addr_in = 16'h2001;
    tick();
    mem_data_in = 8'h22;
    check("t6_ack_a",     cpu_ack_out, 1);
    check("t6_data_a",    cpu_data_out, 8'h11);
    tick();
    check("t6_gap_ack",   cpu_ack_out, 0);
    check("t6_gap_state", dut.state_q, IDLE);
    check("t6_gap_mreq",  mem_req_out, 0);
    tick();
    cpu_idle();
    check("t6_mreq_b",    mem_req_out, 1);
    check("t6_maddr_b",   mem_addr_out, 16'h2001);
    check("t6_ack_b_early", cpu_ack_out, 0);
    tick();
    mem_ready_in = 1'b0;
    mem_data_in  = 8'h00;
    check("t6_ack_b",     cpu_ack_out, 1);
    check("t6_data_b",    cpu_data_out, 8'h22);
    tick();
    tick();
    check("t6_two_acks",  ack_cnt - a0, 2);

    // 6b: ready withheld 300 cycles; default instance times out, shadow does not
    n0 = nt_ack_cnt;
    cpu_req(16'h3000, 8'h00, 1'b0);
    tick();
    cpu_idle();
    check("t6_to_mreq",    mem_req_out, 1);
    check("t6_nt_mreq",    nt_mem_req_out, 1);
    repeat (254) tick();
    check("t6_to_pre_ack", cpu_ack_out, 0);
    check("t6_to_pre_req", mem_req_out, 1);
    tick();
    check("t6_to_ack",     cpu_ack_out, 1);
    check("t6_to_err",     cpu_err_out, 1);
    check("t6_to_data",    cpu_data_out, 8'hFF);
    check("t6_to_req_off", mem_req_out, 0);
    check("t6_nt_hold",    nt_mem_req_out, 1);
    check("t6_nt_no_ack",  nt_cpu_ack_out, 0);
    for (int i = 0; i < 44; i++) tick();
    check("t6_nt_req300",  nt_mem_req_out, 1);
    check("t6_nt_acks",    nt_ack_cnt - n0, 0);
    check("t6_nt_addr",    nt_mem_addr_out, 16'h3000);
    mem_ready_in = 1'b1;
    mem_data_in  = 8'h6B;
    tick();
    mem_ready_in = 1'b0;
    mem_data_in  = 8'h00;
    check("t6_nt_ack",     nt_cpu_ack_out, 1);
    check("t6_nt_err",     nt_cpu_err_out, 0);
    check("t6_nt_data",    nt_cpu_data_out, 8'h6B);
    check("t6_main_quiet", cpu_ack_out, 0);
    check("t6_main_data",  cpu_data_out, 8'hFF);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
